// File: rtl/pipeline_hazard_ctrl.sv
// pipeline_hazard_ctrl: load-use / branch / divide hazard controller for the
// five-stage RV32IM pipeline. Drives stall, flush and bubble controls of the
// PC, IF/ID, ID/EX and EX/MEM registers.
// Optional performance counters are built when HAZARD_PERF_CNT_EN is defined;
// otherwise STALL_CNT and FLUSH_CNT are tied to zero.
module pipeline_hazard_ctrl #(
   parameter int unsigned DIV_TIMEOUT = 64,
   parameter int unsigned CNT_W       = 32
) (
   input  logic             CLK,
   input  logic             RST,
   input  logic [4:0]       ID_RS1,
   input  logic [4:0]       ID_RS2,
   input  logic             ID_USES_RS1,
   input  logic             ID_USES_RS2,
   input  logic [4:0]       EX_RD,
   input  logic             EX_MEM_READ,
   input  logic             EX_WRITE_ENABLE,
   input  logic             EX_BRANCH_TAKEN,
   input  logic             EX_DIV_START,
   input  logic             EX_DIV_DONE,
   output logic             PC_STALL,
   output logic             IF_ID_STALL,
   output logic             IF_ID_FLUSH,
   output logic             ID_EX_STALL,
   output logic             ID_EX_FLUSH,
   output logic             EX_MEM_BUBBLE,
   output logic             DIV_ERR,
   output logic [CNT_W-1:0] STALL_CNT,
   output logic [CNT_W-1:0] FLUSH_CNT
);

   typedef enum logic [1:0] {RUN, LU_STALL, DIV_WAIT} state_t;

   localparam logic [7:0] DIV_LAST = 8'(DIV_TIMEOUT - 1);

   state_t     state_q, state_d;
   logic [7:0] div_cnt_q, div_cnt_d;
   logic       div_err_q, div_err_d;
   logic       load_use;

   assign load_use = EX_MEM_READ && EX_WRITE_ENABLE && (EX_RD != 5'd0) &&
                     ((ID_USES_RS1 && (ID_RS1 == EX_RD)) ||
                      (ID_USES_RS2 && (ID_RS2 == EX_RD)));

   // State, divide counter and sticky error flag registers.
   always_ff @(posedge CLK) begin
      if (!RST) begin
         state_q   <= RUN;
         div_cnt_q <= '0;
         div_err_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         div_cnt_q <= div_cnt_d;
         div_err_q <= div_err_d;
      end
   end

   // Next-state and Mealy control outputs; everything released during reset.
   always_comb begin
      state_d       = state_q;
      div_cnt_d     = div_cnt_q;
      div_err_d     = div_err_q;
      PC_STALL      = 1'b0;
      IF_ID_STALL   = 1'b0;
      IF_ID_FLUSH   = 1'b0;
      ID_EX_STALL   = 1'b0;
      ID_EX_FLUSH   = 1'b0;
      EX_MEM_BUBBLE = 1'b0;
      if (RST) begin
         unique case (state_q)
            RUN: begin
               if (EX_BRANCH_TAKEN) begin
                  IF_ID_FLUSH = 1'b1;
                  ID_EX_FLUSH = 1'b1;
               end else if (EX_DIV_START && !EX_DIV_DONE) begin
                  PC_STALL      = 1'b1;
                  IF_ID_STALL   = 1'b1;
                  ID_EX_STALL   = 1'b1;
                  EX_MEM_BUBBLE = 1'b1;
                  div_cnt_d     = '0;
                  state_d       = DIV_WAIT;
               end else if (load_use) begin
                  PC_STALL    = 1'b1;
                  IF_ID_STALL = 1'b1;
                  ID_EX_FLUSH = 1'b1;
                  state_d     = LU_STALL;
               end
            end
            LU_STALL: begin
               // Load-use detection is masked here so the penalty is one cycle.
               if (EX_BRANCH_TAKEN) begin
                  IF_ID_FLUSH = 1'b1;
                  ID_EX_FLUSH = 1'b1;
               end
               state_d = RUN;
            end
            DIV_WAIT: begin
               if (EX_DIV_DONE) begin
                  state_d = RUN;
               end else if (div_cnt_q == DIV_LAST) begin
                  div_err_d = 1'b1;
                  state_d   = RUN;
               end else begin
                  PC_STALL      = 1'b1;
                  IF_ID_STALL   = 1'b1;
                  ID_EX_STALL   = 1'b1;
                  EX_MEM_BUBBLE = 1'b1;
                  div_cnt_d     = div_cnt_q + 8'd1;
               end
            end
            default: state_d = RUN;
         endcase
      end
   end

   assign DIV_ERR = div_err_q;

`ifdef HAZARD_PERF_CNT_EN
   logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
   logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

   // Saturating next values for the stall-cycle and flush-event counters.
   always_comb begin
      stall_cnt_d = stall_cnt_q;
      flush_cnt_d = flush_cnt_q;
      if (PC_STALL && (stall_cnt_q != '1)) stall_cnt_d = stall_cnt_q + CNT_W'(1);
      if (IF_ID_FLUSH && (flush_cnt_q != '1)) flush_cnt_d = flush_cnt_q + CNT_W'(1);
   end

   // Performance counter registers.
   always_ff @(posedge CLK) begin
      if (!RST) begin
         stall_cnt_q <= '0;
         flush_cnt_q <= '0;
      end else begin
         stall_cnt_q <= stall_cnt_d;
         flush_cnt_q <= flush_cnt_d;
      end
   end

   assign STALL_CNT = stall_cnt_q;
   assign FLUSH_CNT = flush_cnt_q;
`else
   assign STALL_CNT = '0;
   assign FLUSH_CNT = '0;
`endif

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Testbench for pipeline_hazard_ctrl. Two instances share the stimulus:
// u_a with default parameters and u_b with DIV_TIMEOUT=8, CNT_W=4.
// Counter expectations follow HAZARD_PERF_CNT_EN when it is defined.
module tb_pipeline_hazard_ctrl;

   localparam int TO_A = 64;
   localparam int TO_B = 8;
   localparam logic [5:0] C_LU  = 6'b110010;
   localparam logic [5:0] C_BR  = 6'b001010;
   localparam logic [5:0] C_DIV = 6'b110101;

   logic       CLK = 1'b0;
   logic       RST = 1'b0;
   logic [4:0] ID_RS1, ID_RS2, EX_RD;
   logic       ID_USES_RS1, ID_USES_RS2, EX_MEM_READ, EX_WRITE_ENABLE;
   logic       EX_BRANCH_TAKEN, EX_DIV_START, EX_DIV_DONE;

   logic        a_pc, a_ifs, a_iff, a_ids, a_idf, a_bub, a_err;
   logic [31:0] a_scnt, a_fcnt;
   logic        b_pc, b_ifs, b_iff, b_ids, b_idf, b_bub, b_err;
   logic [3:0]  b_scnt, b_fcnt;

   logic [5:0]  act_ctl  [2];
   logic        act_err  [2];
   logic [31:0] act_scnt [2];
   logic [31:0] act_fcnt [2];

   assign act_ctl[0]  = {a_pc, a_ifs, a_iff, a_ids, a_idf, a_bub};
   assign act_ctl[1]  = {b_pc, b_ifs, b_iff, b_ids, b_idf, b_bub};
   assign act_err[0]  = a_err;
   assign act_err[1]  = b_err;
   assign act_scnt[0] = a_scnt;
   assign act_scnt[1] = {28'd0, b_scnt};
   assign act_fcnt[0] = a_fcnt;
   assign act_fcnt[1] = {28'd0, b_fcnt};

   pipeline_hazard_ctrl u_a (
      .CLK(CLK), .RST(RST), .ID_RS1(ID_RS1), .ID_RS2(ID_RS2),
      .ID_USES_RS1(ID_USES_RS1), .ID_USES_RS2(ID_USES_RS2), .EX_RD(EX_RD),
      .EX_MEM_READ(EX_MEM_READ), .EX_WRITE_ENABLE(EX_WRITE_ENABLE),
      .EX_BRANCH_TAKEN(EX_BRANCH_TAKEN), .EX_DIV_START(EX_DIV_START),
      .EX_DIV_DONE(EX_DIV_DONE), .PC_STALL(a_pc), .IF_ID_STALL(a_ifs),
      .IF_ID_FLUSH(a_iff), .ID_EX_STALL(a_ids), .ID_EX_FLUSH(a_idf),
      .EX_MEM_BUBBLE(a_bub), .DIV_ERR(a_err), .STALL_CNT(a_scnt),
      .FLUSH_CNT(a_fcnt)
   );

   pipeline_hazard_ctrl #(.DIV_TIMEOUT(TO_B), .CNT_W(4)) u_b (
      .CLK(CLK), .RST(RST), .ID_RS1(ID_RS1), .ID_RS2(ID_RS2),
      .ID_USES_RS1(ID_USES_RS1), .ID_USES_RS2(ID_USES_RS2), .EX_RD(EX_RD),
      .EX_MEM_READ(EX_MEM_READ), .EX_WRITE_ENABLE(EX_WRITE_ENABLE),
      .EX_BRANCH_TAKEN(EX_BRANCH_TAKEN), .EX_DIV_START(EX_DIV_START),
      .EX_DIV_DONE(EX_DIV_DONE), .PC_STALL(b_pc), .IF_ID_STALL(b_ifs),
      .IF_ID_FLUSH(b_iff), .ID_EX_STALL(b_ids), .ID_EX_FLUSH(b_idf),
      .EX_MEM_BUBBLE(b_bub), .DIV_ERR(b_err), .STALL_CNT(b_scnt),
      .FLUSH_CNT(b_fcnt)
   );

   always #5 CLK = ~CLK;

   int errors = 0;
   int checks = 0;

   // Reference model: divide wait tracked as elapsed cycles (-1 = idle),
   // load-use penalty as a one-cycle flag, counters as plain integers.
   int          m_div  [2] = '{-1, -1};
   bit          m_lu   [2] = '{1'b0, 1'b0};
   bit          m_err  [2] = '{1'b0, 1'b0};
   longint      m_scnt [2] = '{0, 0};
   longint      m_fcnt [2] = '{0, 0};
   logic [5:0]  e_ctl  [2];
   logic        e_err  [2];
   logic [31:0] e_scnt [2];
   logic [31:0] e_fcnt [2];

   // Expected outputs for the current cycle, then advance the model one edge.
   task automatic model_cycle();
      bit lu, was_lu;
      int t;
      longint mx;
      logic [5:0] c;
      lu = EX_MEM_READ && EX_WRITE_ENABLE && (EX_RD != 0) &&
           ((ID_USES_RS1 && ID_RS1 == EX_RD) || (ID_USES_RS2 && ID_RS2 == EX_RD));
      for (int i = 0; i < 2; i++) begin
         t  = (i == 0) ? TO_A : TO_B;
         mx = (i == 0) ? ((longint'(1) << 32) - 1) : 15;
         c  = '0;
         e_err[i]  = m_err[i];
         e_scnt[i] = m_scnt[i][31:0];
         e_fcnt[i] = m_fcnt[i][31:0];
         if (!RST) begin
            m_div[i] = -1; m_lu[i] = 1'b0; m_err[i] = 1'b0;
            m_scnt[i] = 0; m_fcnt[i] = 0;
         end else begin
            was_lu   = m_lu[i];
            m_lu[i]  = 1'b0;
            if (m_div[i] >= 0) begin
               if (EX_DIV_DONE) m_div[i] = -1;
               else if (m_div[i] == t - 1) begin m_div[i] = -1; m_err[i] = 1'b1; end
               else begin c = C_DIV; m_div[i] = m_div[i] + 1; end
            end else if (EX_BRANCH_TAKEN) c = C_BR;
            else if (!was_lu && EX_DIV_START && !EX_DIV_DONE) begin c = C_DIV; m_div[i] = 0; end
            else if (!was_lu && lu) begin c = C_LU; m_lu[i] = 1'b1; end
`ifdef HAZARD_PERF_CNT_EN
            if (c[5] && m_scnt[i] < mx) m_scnt[i] = m_scnt[i] + 1;
            if (c[3] && m_fcnt[i] < mx) m_fcnt[i] = m_fcnt[i] + 1;
`else
            if (mx < 0) m_scnt[i] = 0;
`endif
         end
         e_ctl[i] = c;
      end
   endtask

   task automatic advance();
      @(posedge CLK);
      #1;
   endtask

   task automatic clear_inputs();
      ID_RS1 = '0; ID_RS2 = '0; EX_RD = '0;
      ID_USES_RS1 = 1'b0; ID_USES_RS2 = 1'b0; EX_MEM_READ = 1'b0;
      EX_WRITE_ENABLE = 1'b0; EX_BRANCH_TAKEN = 1'b0;
      EX_DIV_START = 1'b0; EX_DIV_DONE = 1'b0;
   endtask

   task automatic set_load_use();
      clear_inputs();
      EX_MEM_READ = 1'b1; EX_WRITE_ENABLE = 1'b1; EX_RD = 5'd5;
      ID_RS1 = 5'd5; ID_USES_RS1 = 1'b1;
   endtask

   task automatic do_reset();
      clear_inputs();
      RST = 1'b0;
      @(negedge CLK); model_cycle();
      advance();
      RST = 1'b1;
   endtask

   task automatic test_reset();
      set_load_use();
      EX_BRANCH_TAKEN = 1'b1;
      RST = 1'b0;
      @(negedge CLK); model_cycle();
      checks++; if (act_ctl[0] !== 6'b0) begin errors++; $display("FAIL reset_ctl_first: got %b expected %b", act_ctl[0], 6'b0); end
      advance();
      @(negedge CLK); model_cycle();
      for (int i = 0; i < 2; i++) begin
         checks++; if (act_ctl[i] !== 6'b0) begin errors++; $display("FAIL reset_ctl inst%0d: got %b expected %b", i, act_ctl[i], 6'b0); end
         checks++; if (act_err[i] !== 1'b0) begin errors++; $display("FAIL reset_err inst%0d: got %b expected 0", i, act_err[i]); end
         checks++; if (act_scnt[i] !== 32'd0 || act_fcnt[i] !== 32'd0) begin errors++; $display("FAIL reset_cnt inst%0d: got %0d/%0d expected 0/0", i, act_scnt[i], act_fcnt[i]); end
      end
      advance();
      RST = 1'b1;
   endtask

   task automatic test_load_use();
      logic [5:0] exp [6];
      do_reset();
      exp = '{C_LU, 6'b0, 6'b0, 6'b0, C_LU, 6'b0};
      for (int k = 0; k < 6; k++) begin
         set_load_use();
         if (k == 2) EX_RD = 5'd0;
         if (k == 3) ID_USES_RS1 = 1'b0;
         if (k == 4) begin ID_RS1 = 5'd7; ID_USES_RS2 = 1'b1; ID_RS2 = 5'd5; end
         if (k == 5) begin ID_RS1 = 5'd7; ID_USES_RS2 = 1'b1; ID_RS2 = 5'd5; end
         @(negedge CLK); model_cycle();
         checks++; if (act_ctl[0] !== exp[k]) begin errors++; $display("FAIL load_use step%0d: got %b expected %b", k, act_ctl[0], exp[k]); end
         advance();
      end
   endtask

   task automatic test_branch_priority();
      logic [5:0] exp [4];
      do_reset();
      exp = '{C_BR, C_LU, C_BR, 6'b0};
      for (int k = 0; k < 4; k++) begin
         set_load_use();
         EX_BRANCH_TAKEN = (k == 0 || k == 2);
         if (k == 3) clear_inputs();
         @(negedge CLK); model_cycle();
         checks++; if (act_ctl[0] !== exp[k]) begin errors++; $display("FAIL branch_prio step%0d: got %b expected %b", k, act_ctl[0], exp[k]); end
         advance();
      end
   endtask

   task automatic test_div_done();
      int stalls = 0;
      logic [5:0] exp;
      do_reset();
      for (int c = 0; c <= 34; c++) begin
         clear_inputs();
         EX_DIV_START = (c == 0);
         EX_DIV_DONE  = (c == 34);
         if (c > 0 && c < 34) begin
            EX_BRANCH_TAKEN = 1'($urandom_range(1));
            EX_MEM_READ = 1'b1; EX_WRITE_ENABLE = 1'b1;
            EX_RD = 5'd3; ID_RS1 = 5'd3; ID_USES_RS1 = 1'b1;
         end
         @(negedge CLK); model_cycle();
         exp = (c < 34) ? C_DIV : 6'b0;
         checks++; if (act_ctl[0] !== exp) begin errors++; $display("FAIL div_wait cyc%0d: got %b expected %b", c, act_ctl[0], exp); end
         checks++; if (act_ctl[1] !== e_ctl[1]) begin errors++; $display("FAIL div_wait_b cyc%0d: got %b expected %b", c, act_ctl[1], e_ctl[1]); end
         if (a_pc === 1'b1) stalls++;
         advance();
      end
      checks++; if (stalls != 34) begin errors++; $display("FAIL div_stall_len: got %0d expected 34", stalls); end
      clear_inputs(); EX_DIV_START = 1'b1; EX_DIV_DONE = 1'b1;
      for (int c = 0; c < 2; c++) begin
         @(negedge CLK); model_cycle();
         checks++; if (act_ctl[0] !== 6'b0) begin errors++; $display("FAIL div_immediate cyc%0d: got %b expected %b", c, act_ctl[0], 6'b0); end
         advance();
         clear_inputs();
      end
   endtask

   task automatic test_div_timeout();
      int stalls = 0;
      logic [5:0] exp;
      do_reset();
      for (int c = 0; c <= TO_B; c++) begin
         clear_inputs();
         EX_DIV_START = (c == 0);
         @(negedge CLK); model_cycle();
         exp = (c < TO_B) ? C_DIV : 6'b0;
         checks++; if (act_ctl[1] !== exp) begin errors++; $display("FAIL timeout cyc%0d: got %b expected %b", c, act_ctl[1], exp); end
         if (b_pc === 1'b1) stalls++;
         advance();
      end
      checks++; if (stalls != TO_B) begin errors++; $display("FAIL timeout_len: got %0d expected %0d", stalls, TO_B); end
      @(negedge CLK); model_cycle();
      checks++; if (b_err !== 1'b1) begin errors++; $display("FAIL timeout_err: got %b expected 1", b_err); end
      checks++; if (act_ctl[1] !== 6'b0) begin errors++; $display("FAIL timeout_release: got %b expected %b", act_ctl[1], 6'b0); end
      advance();
      // Second run: reset for one edge mid-wait with DIV_ERR already set.
      for (int c = 0; c < 6; c++) begin
         clear_inputs();
         EX_DIV_START = (c == 0);
         RST = (c != 4);
         @(negedge CLK); model_cycle();
         exp = (c < 4) ? C_DIV : 6'b0;
         checks++; if (act_ctl[1] !== exp) begin errors++; $display("FAIL div_reset cyc%0d: got %b expected %b", c, act_ctl[1], exp); end
         if (c == 5) begin
            checks++; if (b_err !== 1'b0) begin errors++; $display("FAIL div_reset_err: got %b expected 0", b_err); end
         end
         advance();
      end
   endtask

   task automatic test_perf_counters();
      logic [31:0] exp_s, exp_f, exp_sb;
      do_reset();
      for (int k = 0; k < 5; k++) begin
         if (k < 3) set_load_use();
         else begin clear_inputs(); EX_BRANCH_TAKEN = 1'b1; end
         @(negedge CLK); model_cycle(); advance();
         clear_inputs();
         @(negedge CLK); model_cycle(); advance();
      end
`ifdef HAZARD_PERF_CNT_EN
      exp_s = 32'd3; exp_f = 32'd2;
`else
      exp_s = 32'd0; exp_f = 32'd0;
`endif
      @(negedge CLK); model_cycle();
      checks++; if (act_scnt[0] !== exp_s) begin errors++; $display("FAIL stall_cnt: got %0d expected %0d", act_scnt[0], exp_s); end
      checks++; if (act_fcnt[0] !== exp_f) begin errors++; $display("FAIL flush_cnt: got %0d expected %0d", act_fcnt[0], exp_f); end
      advance();
      for (int k = 0; k < 20; k++) begin
         set_load_use();
         @(negedge CLK); model_cycle(); advance();
         clear_inputs();
         @(negedge CLK); model_cycle(); advance();
      end
`ifdef HAZARD_PERF_CNT_EN
      exp_s = 32'd23; exp_sb = 32'd15;
`else
      exp_s = 32'd0; exp_sb = 32'd0;
`endif
      @(negedge CLK); model_cycle();
      checks++; if (act_scnt[0] !== exp_s) begin errors++; $display("FAIL stall_cnt_wide: got %0d expected %0d", act_scnt[0], exp_s); end
      checks++; if (act_scnt[1] !== exp_sb) begin errors++; $display("FAIL stall_cnt_sat: got %0d expected %0d", act_scnt[1], exp_sb); end
      advance();
   endtask

   task automatic test_random();
      do_reset();
      for (int n = 0; n < 600; n++) begin
         RST             = ($urandom_range(99) >= 2);
         ID_RS1          = 5'($urandom_range(3));
         ID_RS2          = 5'($urandom_range(3));
         EX_RD           = 5'($urandom_range(3));
         ID_USES_RS1     = 1'($urandom_range(1));
         ID_USES_RS2     = 1'($urandom_range(1));
         EX_MEM_READ     = ($urandom_range(99) < 50);
         EX_WRITE_ENABLE = ($urandom_range(99) < 80);
         EX_BRANCH_TAKEN = ($urandom_range(99) < 12);
         EX_DIV_START    = ($urandom_range(99) < 15);
         EX_DIV_DONE     = ($urandom_range(99) < (n < 300 ? 4 : 20));
         @(negedge CLK); model_cycle();
         for (int i = 0; i < 2; i++) begin
            checks++; if (act_ctl[i] !== e_ctl[i]) begin errors++; $display("FAIL rand_ctl n%0d inst%0d: got %b expected %b", n, i, act_ctl[i], e_ctl[i]); end
            checks++; if (act_err[i] !== e_err[i]) begin errors++; $display("FAIL rand_err n%0d inst%0d: got %b expected %b", n, i, act_err[i], e_err[i]); end
            checks++; if (act_scnt[i] !== e_scnt[i]) begin errors++; $display("FAIL rand_scnt n%0d inst%0d: got %0d expected %0d", n, i, act_scnt[i], e_scnt[i]); end
            checks++; if (act_fcnt[i] !== e_fcnt[i]) begin errors++; $display("FAIL rand_fcnt n%0d inst%0d: got %0d expected %0d", n, i, act_fcnt[i], e_fcnt[i]); end
         end
         advance();
      end
      RST = 1'b1;
   endtask

   initial begin
      clear_inputs();
      test_reset();
      test_load_use();
      test_branch_priority();
      test_div_done();
      test_div_timeout();
      test_perf_counters();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

endmodule
